mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter with byte/half/word lane steering.
// One access per cycle; responses return one cycle after grant, in grant order.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS = 32768,
    parameter int unsigned AW        = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [1:0]    r0_size,
    input  logic          r0_unsigned,
    input  logic [31:0]   r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic          r0_err,
    output logic [31:0]   r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [1:0]    r1_size,
    input  logic          r1_unsigned,
    input  logic [31:0]   r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic          r1_err,
    output logic [31:0]   r1_rdata,

    output logic          mem_en,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [32:0] ByteLimit = 33'(MEM_WORDS) << 2;

    typedef struct packed {
        logic       valid;
        logic       owner;
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
        logic       err;
    } resp_t;

    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
        logic e;
        e = 1'b0;
        case (size)
            2'd0:    e = 1'b0;
            2'd1:    e = addr[0];
            2'd2:    e = |addr[1:0];
            default: e = 1'b1;
        endcase
        if ({1'b0, addr} >= ByteLimit) begin
            e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] size);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wd[7:0]}};
            2'd1:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] lane, input logic [1:0] size,
                                                input logic uns);
        logic [31:0] d;
        case (size)
            2'd0:    d = uns ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'd1:    d = uns ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: d = lane;
        endcase
        return d;
    endfunction

    // last_gnt_q: 0 = r0 granted most recently, 1 = r1.
    logic        last_gnt_q, last_gnt_d;
    resp_t       resp_q, resp_d;

    logic        gnt0, gnt1, any_gnt;
    logic        sel_we, sel_uns, sel_err, issue;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;
    logic [31:0] rd_lane, resp_data;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (r0_req && (!r1_req || last_gnt_q)) begin
                gnt0 = 1'b1;
            end else if (r1_req) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign any_gnt = gnt0 | gnt1;
    assign r0_gnt  = gnt0;
    assign r1_gnt  = gnt1;

    always_comb begin
        sel_we    = gnt1 ? r1_we       : r0_we;
        sel_uns   = gnt1 ? r1_unsigned : r0_unsigned;
        sel_addr  = gnt1 ? r1_addr     : r0_addr;
        sel_size  = gnt1 ? r1_size     : r0_size;
        sel_wdata = gnt1 ? r1_wdata    : r0_wdata;
        sel_err   = access_err(sel_addr, sel_size);
        issue     = any_gnt && !sel_err;
    end

    always_comb begin
        mem_en    = issue;
        mem_addr  = issue ? sel_addr[AW+1:2] : '0;
        mem_be    = (issue && sel_we) ? store_strobe(sel_addr[1:0], sel_size) : 4'b0000;
        mem_wdata = (issue && sel_we) ? store_lanes(sel_wdata, sel_size) : 32'd0;
    end

    always_comb begin
        last_gnt_d   = any_gnt ? gnt1 : last_gnt_q;
        resp_d       = '0;
        resp_d.valid = any_gnt;
        resp_d.owner = gnt1;
        resp_d.we    = sel_we;
        resp_d.size  = sel_size;
        resp_d.uns   = sel_uns;
        resp_d.off   = sel_addr[1:0];
        resp_d.err   = sel_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            resp_q     <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            resp_q     <= resp_d;
        end
    end

    // Stores and rejected accesses answer with zero data.
    always_comb begin
        rd_lane   = mem_rdata >> {resp_q.off, 3'b000};
        resp_data = (resp_q.err || resp_q.we) ? 32'd0
                                              : load_extend(rd_lane, resp_q.size, resp_q.uns);
        r0_rvalid = resp_q.valid && !resp_q.owner;
        r1_rvalid = resp_q.valid && resp_q.owner;
        r0_err    = r0_rvalid && resp_q.err;
        r1_err    = r1_rvalid && resp_q.err;
        r0_rdata  = r0_rvalid ? resp_data : 32'd0;
        r1_rdata  = r1_rvalid ? resp_data : 32'd0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a byte-addressed memory and round-robin reference model.
module tb_mem_arbiter;

    localparam int unsigned MemWords = 32768;
    localparam int unsigned Aw       = 15;
    localparam int unsigned RefBytes = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_req = 1'b0, r0_we = 1'b0, r0_unsigned = 1'b0;
    logic [31:0]   r0_addr = '0, r0_wdata = '0;
    logic [1:0]    r0_size = '0;
    logic          r1_req = 1'b0, r1_we = 1'b0, r1_unsigned = 1'b0;
    logic [31:0]   r1_addr = '0, r1_wdata = '0;
    logic [1:0]    r1_size = '0;
    logic          r0_gnt, r0_rvalid, r0_err, r1_gnt, r1_rvalid, r1_err;
    logic [31:0]   r0_rdata, r1_rdata;
    logic          mem_en;
    logic [3:0]    mem_be;
    logic [Aw-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;

    logic [7:0]  ref_mem [0:RefBytes-1];
    logic [31:0] ram     [0:MemWords-1];
    bit          ram_vld [0:MemWords-1];

    mem_arbiter #(.MEM_WORDS(MemWords), .AW(Aw)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_size(r0_size),
        .r0_unsigned(r0_unsigned), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_size(r1_size),
        .r1_unsigned(r1_unsigned), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_en(mem_en), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    function automatic logic [31:0] init_word(input int unsigned wa);
        return {init_byte(4*wa+3), init_byte(4*wa+2), init_byte(4*wa+1), init_byte(4*wa)};
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] base, input logic [31:0] d,
                                               input logic [3:0] be);
        logic [31:0] w;
        w = base;
        for (int k = 0; k < 4; k++) if (be[k]) w[8*k +: 8] = d[8*k +: 8];
        return w;
    endfunction

    // Backing RAM: unwritten words read as their initial pattern.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_be == 4'b0000) begin
                mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : init_word(32'(mem_addr));
            end else begin
                ram[mem_addr] <= merge_word(ram_vld[mem_addr] ? ram[mem_addr]
                                                              : init_word(32'(mem_addr)),
                                            mem_wdata, mem_be);
                ram_vld[mem_addr] <= 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) ||
               (a >= 32'(4 * MemWords));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input bit uns);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[10'(a + 32'(k))]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int k = 0; k < nbytes(sz); k++) ref_mem[10'(a + 32'(k))] = wd[8*k +: 8];
    endtask

    task automatic drive(input int n, input bit req, input bit we, input logic [31:0] a,
                         input logic [1:0] sz, input bit uns, input logic [31:0] wd);
        if (n == 0) begin
            r0_req = req; r0_we = we; r0_addr = a; r0_size = sz; r0_unsigned = uns; r0_wdata = wd;
        end else begin
            r1_req = req; r1_we = we; r1_addr = a; r1_size = sz; r1_unsigned = uns; r1_wdata = wd;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1, 1, 32'h4, 2'd2, 0, 32'h1234_5678);
        drive(1, 1, 0, 32'h8, 2'd2, 0, 32'h0);
        @(negedge clk);
        #1;
        n_tests++;
        if ({r1_gnt, r0_gnt} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt: got %b expected 00", {r1_gnt, r0_gnt});
        end
        n_tests++;
        if ({mem_en, mem_be} !== 5'b0) begin
            n_fail++; $display("FAIL reset_mem_en_be: got %b expected 00000", {mem_en, mem_be});
        end
        n_tests++;
        if (mem_addr !== '0 || mem_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_mem_addr_wdata: got %h/%h expected 0/0", mem_addr, mem_wdata);
        end
        n_tests++;
        if ({r1_rvalid, r1_err, r0_rvalid, r0_err} !== 4'b0 || r0_rdata !== 0 || r1_rdata !== 0) begin
            n_fail++; $display("FAIL reset_resp: got %b %h %h expected 0000 0 0",
                               {r1_rvalid, r1_err, r0_rvalid, r0_err}, r0_rdata, r1_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Contention right after reset release: r0 first, then r1, responses in order.
    task automatic test_contention();
        drive(0, 1, 0, 32'h10, 2'd2, 0, 0);
        drive(1, 1, 0, 32'h20, 2'd2, 0, 0);
        #1;
        n_tests++;
        if ({r1_gnt, r0_gnt, mem_en, mem_be, mem_addr} !== {2'b01, 1'b1, 4'b0, Aw'(4)}) begin
            n_fail++; $display("FAIL contention_c0: got gnt=%b en=%b be=%b addr=%h expected 01 1 0000 4",
                               {r1_gnt, r0_gnt}, mem_en, mem_be, mem_addr);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({r1_gnt, r0_gnt, mem_addr} !== {2'b10, Aw'(8)}) begin
            n_fail++; $display("FAIL contention_c1_gnt: got gnt=%b addr=%h expected 10 8",
                               {r1_gnt, r0_gnt}, mem_addr);
        end
        n_tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== model_load(32'h10, 2'd2, 0)) begin
            n_fail++; $display("FAIL contention_r0_resp: got %b %h expected 1 %h",
                               r0_rvalid, r0_rdata, model_load(32'h10, 2'd2, 0));
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({r1_rvalid, r0_rvalid} !== 2'b10 || r1_rdata !== model_load(32'h20, 2'd2, 0)) begin
            n_fail++; $display("FAIL contention_r1_resp: got %b %h expected 10 %h",
                               {r1_rvalid, r0_rvalid}, r1_rdata, model_load(32'h20, 2'd2, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        drive(0, 1, 1, 32'h103, 2'd0, 0, 32'h1234_56A5);
        #1;
        n_tests++;
        if ({r0_gnt, mem_en, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 4'b1000, Aw'(32'h40), 32'hA5A5_A5A5}) begin
            n_fail++; $display("FAIL store_byte_issue: got gnt=%b en=%b be=%b addr=%h wd=%h expected 1 1 1000 40 a5a5a5a5",
                               r0_gnt, mem_en, mem_be, mem_addr, mem_wdata);
        end
        model_store(32'h103, 2'd0, 32'h1234_56A5);
        @(negedge clk);
        drive(0, 1, 0, 32'h100, 2'd2, 0, 0);
        #1;
        n_tests++;
        if ({r0_rvalid, r0_err, r0_rdata} !== {2'b10, 32'd0}) begin
            n_fail++; $display("FAIL store_byte_resp: got %b %b %h expected 1 0 0", r0_rvalid, r0_err, r0_rdata);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== model_load(32'h100, 2'd2, 0)) begin
            n_fail++; $display("FAIL store_byte_readback: got %b %h expected 1 %h",
                               r0_rvalid, r0_rdata, model_load(32'h100, 2'd2, 0));
        end
        @(negedge clk);
    endtask

    task automatic test_extend();
        logic [31:0] la [3];
        logic [1:0]  ls [3];
        bit          lu [3];
        logic [31:0] ex [3];
        la = '{32'h2, 32'h2, 32'h3};
        ls = '{2'd0, 2'd1, 2'd0};
        lu = '{1'b0, 1'b1, 1'b0};
        ex = '{32'hFFFF_FFFF, 32'h0000_80FF, 32'hFFFF_FF80};
        drive(1, 1, 1, 32'h0, 2'd2, 0, 32'h80FF_7F01);
        model_store(32'h0, 2'd2, 32'h80FF_7F01);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, 1, 0, la[i], ls[i], lu[i], 0);
            else drive(1, 0, 0, 0, 0, 0, 0);
            #1;
            if (i < 3) begin
                n_tests++;
                if (r1_gnt !== 1'b1) begin
                    n_fail++; $display("FAIL extend_gnt%0d: got %b expected 1", i, r1_gnt);
                end
            end
            n_tests++;
            if (i == 0) begin
                if (r1_rvalid !== 1'b1 || r1_rdata !== 32'd0) begin
                    n_fail++; $display("FAIL extend_store_resp: got %b %h expected 1 0", r1_rvalid, r1_rdata);
                end
            end else if (r1_rvalid !== 1'b1 || r1_rdata !== ex[i-1]) begin
                n_fail++; $display("FAIL extend_load%0d: got %b %h expected 1 %h", i - 1, r1_rvalid, r1_rdata, ex[i-1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_errors();
        drive(0, 1, 0, 32'h5, 2'd1, 0, 0);
        #1;
        n_tests++;
        if ({r0_gnt, mem_en} !== 2'b10) begin
            n_fail++; $display("FAIL err_half_issue: got gnt/en %b expected 10", {r0_gnt, mem_en});
        end
        @(negedge clk);
        drive(0, 1, 0, 32'h0002_0000, 2'd2, 0, 0);
        #1;
        n_tests++;
        if ({r0_gnt, mem_en} !== 2'b10) begin
            n_fail++; $display("FAIL err_range_issue: got gnt/en %b expected 10", {r0_gnt, mem_en});
        end
        n_tests++;
        if ({r0_rvalid, r0_err, r0_rdata} !== {2'b11, 32'd0}) begin
            n_fail++; $display("FAIL err_half_resp: got %b %b %h expected 1 1 0", r0_rvalid, r0_err, r0_rdata);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({r0_rvalid, r0_err, r0_rdata} !== {2'b11, 32'd0}) begin
            n_fail++; $display("FAIL err_range_resp: got %b %b %h expected 1 1 0", r0_rvalid, r0_err, r0_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        drive(1, 1, 0, 32'h30, 2'd2, 0, 0);
        #1;
        n_tests++;
        if ({r1_gnt, r0_gnt} !== 2'b10) begin
            n_fail++; $display("FAIL alt_prime: got %b expected 10", {r1_gnt, r0_gnt});
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, 32'h40, 2'd2, 0, 0);
            drive(1, 1, 0, 32'h44, 2'd2, 0, 0);
            #1;
            n_tests++;
            if ({r1_gnt, r0_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL alt_cycle%0d: got %b expected %b", i, {r1_gnt, r0_gnt},
                                   (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_reset_pending();
        drive(1, 1, 0, 32'h40, 2'd2, 0, 0);
        #1;
        n_tests++;
        if (r1_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rstpend_gnt: got %b expected 1", r1_gnt);
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({r1_rvalid, r1_rdata} !== 33'd0) begin
            n_fail++; $display("FAIL rstpend_during: got %b %h expected 0 0", r1_rvalid, r1_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1, 0, 32'h50, 2'd2, 0, 0);
        drive(1, 1, 0, 32'h54, 2'd2, 0, 0);
        #1;
        n_tests++;
        if ({r1_rvalid, r1_gnt, r0_gnt} !== 3'b001) begin
            n_fail++; $display("FAIL rstpend_after: got rv/gnt %b expected 001", {r1_rvalid, r1_gnt, r0_gnt});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_tests++;
        if ({r1_gnt, r0_rvalid, r1_rvalid} !== 3'b110) begin
            n_fail++; $display("FAIL rstpend_next: got gnt1/rv0/rv1 %b expected 110", {r1_gnt, r0_rvalid, r1_rvalid});
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        last_win = 1;
    endtask

    task automatic test_random(input int cycles);
        bit          p_v [2];
        bit          p_we [2];
        bit          p_uns [2];
        logic [31:0] p_a [2];
        logic [31:0] p_wd [2];
        logic [1:0]  p_sz [2];
        bit          exp_v, exp_err, e, got_v, got_e;
        int          exp_own, win;
        logic [31:0] exp_data, got_d, a;
        logic [1:0]  eg;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        p_v = '{0, 0};
        exp_v = 0; exp_own = 0; exp_err = 0; exp_data = 0;
        for (int c = 0; c <= cycles; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (c < cycles && !p_v[n] && $urandom_range(0, 9) < 6) begin
                    p_v[n]   = 1'b1;
                    p_we[n]  = 1'($urandom_range(0, 1));
                    p_uns[n] = 1'($urandom_range(0, 1));
                    p_wd[n]  = $urandom;
                    p_sz[n]  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    if ($urandom_range(0, 19) == 0) begin
                        p_a[n] = 32'h0002_0000 + $urandom_range(0, 32'h00FF_FFFF);
                    end else begin
                        p_a[n] = $urandom_range(0, RefBytes - 1);
                        if (p_sz[n] != 2'd3 && $urandom_range(0, 3) != 0)
                            p_a[n] = p_a[n] - p_a[n] % (32'd1 << p_sz[n]);
                    end
                end
                drive(n, p_v[n], p_we[n], p_a[n], p_sz[n], p_uns[n], p_wd[n]);
            end
            #1;
            if (p_v[0] && p_v[1]) win = (last_win == 0) ? 1 : 0;
            else if (p_v[0]) win = 0;
            else if (p_v[1]) win = 1;
            else win = -1;
            eg = (win < 0) ? 2'b00 : (win == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if ({r1_gnt, r0_gnt} !== eg) begin
                n_fail++; $display("FAIL rand_gnt c%0d: got %b expected %b", c, {r1_gnt, r0_gnt}, eg);
            end
            for (int n = 0; n < 2; n++) begin
                got_v = (n == 0) ? r0_rvalid : r1_rvalid;
                got_e = (n == 0) ? r0_err : r1_err;
                got_d = (n == 0) ? r0_rdata : r1_rdata;
                n_tests++;
                if (got_v !== (exp_v && exp_own == n) || got_e !== (exp_v && exp_own == n && exp_err) ||
                    got_d !== ((exp_v && exp_own == n) ? exp_data : 32'd0)) begin
                    n_fail++; $display("FAIL rand_resp%0d c%0d: got v=%b e=%b d=%h expected v=%b e=%b d=%h",
                                       n, c, got_v, got_e, got_d, exp_v && exp_own == n,
                                       exp_v && exp_own == n && exp_err,
                                       (exp_v && exp_own == n) ? exp_data : 32'd0);
                end
            end
            if (win >= 0) begin
                a = p_a[win];
                e = model_err(a, p_sz[win]);
                n_tests++;
                if (mem_en !== !e) begin
                    n_fail++; $display("FAIL rand_mem_en c%0d: got %b expected %b", c, mem_en, !e);
                end
                if (!e) begin
                    ebe = 4'b0;
                    ewd = 32'd0;
                    if (p_we[win]) begin
                        for (int k = 0; k < nbytes(p_sz[win]); k++) ebe[2'(a % 4 + 32'(k))] = 1'b1;
                        ewd = (p_sz[win] == 2'd0) ? {4{p_wd[win][7:0]}} :
                              (p_sz[win] == 2'd1) ? {2{p_wd[win][15:0]}} : p_wd[win];
                    end
                    n_tests++;
                    if (mem_addr !== Aw'(a / 4) || mem_be !== ebe || (p_we[win] && mem_wdata !== ewd)) begin
                        n_fail++; $display("FAIL rand_mem_port c%0d: got a=%h be=%b wd=%h expected a=%h be=%b wd=%h",
                                           c, mem_addr, mem_be, mem_wdata, Aw'(a / 4), ebe, ewd);
                    end
                end
                exp_v    = 1'b1;
                exp_own  = win;
                exp_err  = e;
                exp_data = (e || p_we[win]) ? 32'd0 : model_load(a, p_sz[win], p_uns[win]);
                if (!e && p_we[win]) model_store(a, p_sz[win], p_wd[win]);
                last_win = win;
                p_v[win] = 1'b0;
            end else begin
                exp_v = 1'b0;
                n_tests++;
                if (mem_en !== 1'b0) begin
                    n_fail++; $display("FAIL rand_idle_en c%0d: got %b expected 0", c, mem_en);
                end
            end
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < int'(RefBytes); i++) ref_mem[i] = init_byte(i);
        test_reset();
        test_contention();
        test_store_byte();
        test_extend();
        test_errors();
        test_alternate();
        test_reset_pending();
        test_random(600);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
